// File: rtl/rf_wb_mux.sv
// Register-file write-back stage: picks one of NUM_SRC sources, stalls on slow
// sources with an optional timeout, and issues a registered one-cycle write.
module rf_wb_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4,
  parameter int NUM_REGS   = 4,
  parameter int TIMEOUT    = 15,
  localparam int SRC_W     = (NUM_SRC  > 1) ? $clog2(NUM_SRC)  : 1,
  localparam int RA_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_req,
  input  logic [SRC_W-1:0]              wb_src,
  input  logic [RA_W-1:0]               wb_rd,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic                          wb_busy,
  output logic                          rf_we,
  output logic [RA_W-1:0]               rf_waddr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  output logic                          err_src,
  output logic                          err_timeout
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                state, state_nxt;
  logic [SRC_W-1:0]      lat_src, lat_src_nxt;
  logic [RA_W-1:0]       lat_rd, lat_rd_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic                  rf_we_nxt, err_src_nxt, err_timeout_nxt;
  logic [RA_W-1:0]       waddr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;

  logic [SRC_W-1:0]      sel;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  req_legal;
  logic [8:0]            cnt_inc;
  logic                  timeout_hit;

  // In IDLE the live request drives the mux; in WAIT the latched source does.
  assign sel = (state == S_WAIT) ? lat_src : wb_src;

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SRC_W'(i)) begin
        sel_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = src_valid[i];
      end
    end
  end

  assign req_legal   = (32'(wb_src) < NUM_SRC) && (32'(wb_rd) < NUM_REGS);
  assign cnt_inc     = {1'b0, cnt} + 9'd1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc >= 9'(TIMEOUT));
  assign wb_busy     = (state == S_WAIT);

  always_comb begin
    state_nxt       = state;
    lat_src_nxt     = lat_src;
    lat_rd_nxt      = lat_rd;
    cnt_nxt         = cnt;
    rf_we_nxt       = 1'b0;
    err_src_nxt     = 1'b0;
    err_timeout_nxt = 1'b0;
    waddr_nxt       = rf_waddr;
    wdata_nxt       = rf_wdata;
    case (state)
      S_IDLE: begin
        if (wb_req) begin
          if (!req_legal) begin
            err_src_nxt = 1'b1;
          end else if (sel_valid) begin
            rf_we_nxt = 1'b1;
            waddr_nxt = wb_rd;
            wdata_nxt = sel_data;
          end else begin
            state_nxt   = S_WAIT;
            lat_src_nxt = wb_src;
            lat_rd_nxt  = wb_rd;
            cnt_nxt     = '0;
          end
        end
      end
      S_WAIT: begin
        // Valid data wins over a timeout expiring on the same edge.
        if (sel_valid) begin
          rf_we_nxt = 1'b1;
          waddr_nxt = lat_rd;
          wdata_nxt = sel_data;
          state_nxt = S_IDLE;
        end else if (timeout_hit) begin
          err_timeout_nxt = 1'b1;
          state_nxt       = S_IDLE;
        end else begin
          cnt_nxt = (cnt == 8'hFF) ? cnt : cnt_inc[7:0];
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lat_src     <= '0;
      lat_rd      <= '0;
      cnt         <= '0;
      rf_we       <= 1'b0;
      err_src     <= 1'b0;
      err_timeout <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
    end else begin
      state       <= state_nxt;
      lat_src     <= lat_src_nxt;
      lat_rd      <= lat_rd_nxt;
      cnt         <= cnt_nxt;
      rf_we       <= rf_we_nxt;
      err_src     <= err_src_nxt;
      err_timeout <= err_timeout_nxt;
      rf_waddr    <= waddr_nxt;
      rf_wdata    <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_rf_wb_mux.sv
// Directed bench for rf_wb_mux: default build, a 3-source build for illegal
// source indices, and a wide 16-bit / 6-source / 16-register build.
module tb_rf_wb_mux;

  logic clk;
  logic rst_n;

  logic        req_a;
  logic [1:0]  src_a, rd_a;
  logic [31:0] data_a;
  logic [3:0]  valid_a;
  logic        busy_a, we_a, errs_a, errt_a;
  logic [1:0]  waddr_a;
  logic [7:0]  wdata_a;

  logic        req_b;
  logic [1:0]  src_b, rd_b;
  logic [23:0] data_b;
  logic [2:0]  valid_b;
  logic        busy_b, we_b, errs_b, errt_b;
  logic [1:0]  waddr_b;
  logic [7:0]  wdata_b;

  logic        req_c;
  logic [2:0]  src_c;
  logic [3:0]  rd_c;
  logic [95:0] data_c;
  logic [5:0]  valid_c;
  logic        busy_c, we_c, errs_c, errt_c;
  logic [3:0]  waddr_c;
  logic [15:0] wdata_c;

  int tests_run;
  int tests_failed;

  rf_wb_mux #(.DATA_WIDTH(8), .NUM_SRC(4), .NUM_REGS(4), .TIMEOUT(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .wb_req(req_a), .wb_src(src_a), .wb_rd(rd_a),
    .src_data(data_a), .src_valid(valid_a), .wb_busy(busy_a), .rf_we(we_a),
    .rf_waddr(waddr_a), .rf_wdata(wdata_a), .err_src(errs_a), .err_timeout(errt_a));

  rf_wb_mux #(.DATA_WIDTH(8), .NUM_SRC(3), .NUM_REGS(4), .TIMEOUT(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .wb_req(req_b), .wb_src(src_b), .wb_rd(rd_b),
    .src_data(data_b), .src_valid(valid_b), .wb_busy(busy_b), .rf_we(we_b),
    .rf_waddr(waddr_b), .rf_wdata(wdata_b), .err_src(errs_b), .err_timeout(errt_b));

  rf_wb_mux #(.DATA_WIDTH(16), .NUM_SRC(6), .NUM_REGS(16), .TIMEOUT(15)) dut_c (
    .clk(clk), .rst_n(rst_n), .wb_req(req_c), .wb_src(src_c), .wb_rd(rd_c),
    .src_data(data_c), .src_valid(valid_c), .wb_busy(busy_c), .rf_we(we_c),
    .rf_waddr(waddr_c), .rf_wdata(wdata_c), .err_src(errs_c), .err_timeout(errt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [1:0] src, input logic [1:0] rd);
    req_a = req;
    src_a = src;
    rd_a  = rd;
  endtask

  // Advance one clock; outputs are read 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkQuietA(input string tag);
    checkOutput({tag, "_we"},   32'(we_a),    32'd0);
    checkOutput({tag, "_errs"}, 32'(errs_a),  32'd0);
    checkOutput({tag, "_errt"}, 32'(errt_a),  32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_a),  32'd0);
  endtask

  int pulses, pulse_at, wes, busies;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n   = 1'b0;
    applyStimulus(1'b0, 2'd0, 2'd0);
    data_a  = 32'h7E_A5_00_3C;
    valid_a = 4'b0111;
    req_b = 1'b0; src_b = 2'd0; rd_b = 2'd0;
    data_b = {8'h11, 8'h42, 8'h99};
    valid_b = 3'b111;
    req_c = 1'b0; src_c = 3'd0; rd_c = 4'd0;
    data_c = {16'hBEEF, 16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000};
    valid_c = 6'b111111;

    // Reset held with random inputs.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'($urandom), 2'($urandom), 2'($urandom));
      valid_a = 4'($urandom);
      tick();
    end
    checkQuietA("rst");
    checkOutput("rst_waddr", 32'(waddr_a), 32'd0);
    checkOutput("rst_wdata", 32'(wdata_a), 32'd0);
    checkOutput("rst_we_c",  32'(we_c),    32'd0);

    rst_n   = 1'b1;
    applyStimulus(1'b0, 2'd0, 2'd0);
    valid_a = 4'b0111;
    data_a  = 32'h7E_A5_00_3C;
    tick();
    checkQuietA("post_rst");
    checkOutput("post_rst_wdata", 32'(wdata_a), 32'd0);

    // Back-to-back ALU then immediate writes.
    applyStimulus(1'b1, 2'd2, 2'd2);
    tick();
    checkOutput("b2b1_we",    32'(we_a),    32'd1);
    checkOutput("b2b1_waddr", 32'(waddr_a), 32'd2);
    checkOutput("b2b1_wdata", 32'(wdata_a), 32'hA5);
    checkOutput("b2b1_busy",  32'(busy_a),  32'd0);
    applyStimulus(1'b1, 2'd0, 2'd1);
    tick();
    checkOutput("b2b2_we",    32'(we_a),    32'd1);
    checkOutput("b2b2_waddr", 32'(waddr_a), 32'd1);
    checkOutput("b2b2_wdata", 32'(wdata_a), 32'h3C);
    checkOutput("b2b2_busy",  32'(busy_a),  32'd0);
    applyStimulus(1'b0, 2'd0, 2'd0);
    tick();
    checkOutput("hold_we",    32'(we_a),    32'd0);
    checkOutput("hold_waddr", 32'(waddr_a), 32'd1);
    checkOutput("hold_wdata", 32'(wdata_a), 32'h3C);

    // Slow memory source with a request injected during WAIT.
    applyStimulus(1'b1, 2'd3, 2'd3);
    tick();
    applyStimulus(1'b1, 2'd2, 2'd0);
    for (int c = 0; c < 4; c++) begin
      checkOutput("slow_busy",  32'(busy_a), 32'd1);
      checkOutput("slow_no_we", 32'(we_a),   32'd0);
      if (c == 3) valid_a[3] = 1'b1;
      tick();
    end
    applyStimulus(1'b0, 2'd0, 2'd0);
    valid_a[3] = 1'b0;
    checkOutput("slow_we",    32'(we_a),    32'd1);
    checkOutput("slow_waddr", 32'(waddr_a), 32'd3);
    checkOutput("slow_wdata", 32'(wdata_a), 32'h7E);
    checkOutput("slow_busy_end", 32'(busy_a), 32'd0);
    tick();
    checkQuietA("slow_after");
    checkOutput("slow_after_waddr", 32'(waddr_a), 32'd3);

    // Timeout with mem never valid.
    applyStimulus(1'b1, 2'd3, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    pulses = 0; pulse_at = 0; wes = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (errt_a) begin pulses++; pulse_at = t; end
      if (we_a) wes++;
      if (t == 14) checkOutput("to_busy_14", 32'(busy_a), 32'd1);
      if (t == 15) checkOutput("to_busy_15", 32'(busy_a), 32'd0);
    end
    checkOutput("to_pulses", 32'(pulses),   32'd1);
    checkOutput("to_edge",   32'(pulse_at), 32'd15);
    checkOutput("to_no_we",  32'(wes),      32'd0);

    // Valid arriving on the expiring edge wins.
    applyStimulus(1'b1, 2'd3, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    pulses = 0; wes = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (errt_a) pulses++;
      if (we_a) wes++;
    end
    checkOutput("race_early", 32'(pulses + wes), 32'd0);
    data_a[31:24] = 8'h55;
    valid_a[3]    = 1'b1;
    tick();
    checkOutput("race_we",    32'(we_a),    32'd1);
    checkOutput("race_wdata", 32'(wdata_a), 32'h55);
    checkOutput("race_waddr", 32'(waddr_a), 32'd3);
    checkOutput("race_errt",  32'(errt_a),  32'd0);
    valid_a[3] = 1'b0;
    tick();
    checkQuietA("race_after");

    // Reset while waiting.
    applyStimulus(1'b1, 2'd3, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    tick();
    checkOutput("mid_busy_pre", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    tick();
    checkQuietA("mid_rst");
    checkOutput("mid_rst_waddr", 32'(waddr_a), 32'd0);
    checkOutput("mid_rst_wdata", 32'(wdata_a), 32'd0);
    rst_n = 1'b1;
    pulses = 0; wes = 0; busies = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (errt_a) pulses++;
      if (we_a) wes++;
      if (busy_a) busies++;
    end
    checkOutput("mid_no_errt", 32'(pulses), 32'd0);
    checkOutput("mid_no_we",   32'(wes),    32'd0);
    checkOutput("mid_no_busy", 32'(busies), 32'd0);

    // Illegal source index on the 3-source build.
    req_b = 1'b1; src_b = 2'd3; rd_b = 2'd1;
    tick();
    checkOutput("ill_errs", 32'(errs_b), 32'd1);
    checkOutput("ill_we",   32'(we_b),   32'd0);
    checkOutput("ill_busy", 32'(busy_b), 32'd0);
    src_b = 2'd1; rd_b = 2'd2;
    tick();
    checkOutput("ill_next_errs",  32'(errs_b),  32'd0);
    checkOutput("ill_next_we",    32'(we_b),    32'd1);
    checkOutput("ill_next_waddr", 32'(waddr_b), 32'd2);
    checkOutput("ill_next_wdata", 32'(wdata_b), 32'h42);
    req_b = 1'b0;

    // Wide build.
    req_c = 1'b1; src_c = 3'd5; rd_c = 4'd15;
    tick();
    checkOutput("wide_we",    32'(we_c),    32'd1);
    checkOutput("wide_waddr", 32'(waddr_c), 32'd15);
    checkOutput("wide_wdata", 32'(wdata_c), 32'hBEEF);
    src_c = 3'd6; rd_c = 4'd0;
    tick();
    checkOutput("wide_ill_errs", 32'(errs_c),  32'd1);
    checkOutput("wide_ill_we",   32'(we_c),    32'd0);
    checkOutput("wide_hold",     32'(wdata_c), 32'hBEEF);
    src_c = 3'd2; rd_c = 4'd9;
    tick();
    checkOutput("wide2_we",    32'(we_c),    32'd1);
    checkOutput("wide2_waddr", 32'(waddr_c), 32'd9);
    checkOutput("wide2_wdata", 32'(wdata_c), 32'h2222);
    req_c = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rf_wb_mux.md
# rf_wb_mux

Parametrised, registered write-back stage for the CPU register file: selects one of `NUM_SRC` data sources, waits for slow sources such as the memory read path to present valid data, and issues a single-cycle write to the register file. It sits between the control unit and the register-file write port. It generalises the combinational input multiplexer to any data width, source count and register count. It adds stall handshaking, a wait timeout and error reporting.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of every source and of the write data.
- `NUM_SRC`, 4: number of sources; index order is immediate=0, r0=1, alu=2, mem=3 in the default CPU build.
- `NUM_REGS`, 4: registers in the file; `RA_W = max(1, $clog2(NUM_REGS))`.
- `TIMEOUT`, 15: maximum cycles spent in WAIT; 0 disables the timeout. Legal range 0..255.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset; synchronous and active-low.
- `wb_req` in 1: write-back request, sampled each cycle.
- `wb_src` in `SRC_W = max(1, $clog2(NUM_SRC))`: source index for the request.
- `wb_rd` in `RA_W`: destination register.
- `src_data` in `NUM_SRC*DATA_WIDTH`: flattened sources; source i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `src_valid` in `NUM_SRC`: per-source data-valid. Immediate, r0 and ALU are tied high.
- `wb_busy` out 1: stage is waiting on a source; the control unit must stall.
- `rf_we` out 1: register-file write enable, one-cycle pulse.
- `rf_waddr` out `RA_W`: write address.
- `rf_wdata` out `DATA_WIDTH`: write data.
- `err_src` out 1: one-cycle pulse; request named a source index ≥ `NUM_SRC`, or a destination ≥ `NUM_REGS`.
- `err_timeout` out 1: one-cycle pulse; the WAIT state expired.

## Operation
- The FSM has two states.
  - IDLE: ready to accept a request.
  - WAIT: request latched, selected source not yet valid.
- IDLE with `wb_req=1`:
  - Illegal `wb_src` or `wb_rd`: the request is dropped. `err_src` is pulsed next cycle. No write occurs and the state stays IDLE.
  - `src_valid[wb_src]=1`: data, address and source are captured. `rf_we` pulses next cycle and the state stays IDLE.
  - Otherwise: `wb_src` and `wb_rd` are latched, the wait counter is cleared and the state goes to WAIT.
- WAIT:
  - Each cycle, the latched source's `src_valid` is checked.
  - When it is high, that source's `src_data` is captured, `rf_we` pulses next cycle and the state returns to IDLE.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT` with `TIMEOUT≠0`, the state returns to IDLE, `err_timeout` pulses next cycle and no write occurs.
- `wb_req` is ignored in WAIT. No error is raised and nothing is queued.
- `wb_busy = (state == WAIT)`. It is combinational from the state register only, with no input-to-output path.
- `rf_waddr` and `rf_wdata` hold their last written values when `rf_we=0`.
- Width rules:
  - The counter is 8 bits and saturates.
  - Source data passes unmodified; no extension or truncation.

## Timing
- Reset, sampled on a rising edge with `rst_n=0`:
  - State becomes IDLE and the counter is cleared.
  - `rf_we`, `err_src`, `err_timeout` and `wb_busy` = 0.
  - `rf_waddr` = 0 and `rf_wdata` = 0.
- Reset mid-WAIT abandons the pending write silently, with no error pulse.
- Latency, ready source: request at edge N → `rf_we=1` during cycle N+1 with `rf_wdata` equal to the source value sampled at N.
- Latency, slow source: request at N, valid first seen at edge N+k → `rf_we=1` in cycle N+k+1. `wb_busy=1` in cycles N+1..N+k.
- Throughput: one write per cycle for back-to-back ready requests.
- Timeout: the request enters WAIT at N. With no valid, the state returns to IDLE at edge N+TIMEOUT, and `err_timeout=1` plus `wb_busy=0` in cycle N+TIMEOUT+1. If valid arrives on the same edge the counter reaches `TIMEOUT`, the data wins: a write occurs and no error is raised.
- With `TIMEOUT=0`, WAIT is unbounded.
- `rf_we`, `err_src` and `err_timeout` are mutually exclusive in any cycle.

## Test plan
- Reset check: hold `rst_n=0` for 2 cycles with random inputs → all outputs 0; release → still 0 until the first request.
- Back-to-back ALU then immediate writes: ALU=0xA5 to rd=2, then immediate=0x3C to rd=1 on consecutive edges → `rf_we` high for 2 consecutive cycles with (2,0xA5) then (1,0x3C); `wb_busy` stays 0.
- Slow memory source: mem source to rd=3, `src_valid[3]` low for 4 cycles then high with 0x7E → `wb_busy` high for 4 cycles; `rf_we` with (3,0x7E) in the following cycle. A `wb_req` injected during WAIT produces no effect.
- Timeout: `TIMEOUT=15`, mem source never valid → `err_timeout` pulses exactly once, 16 cycles after the request edge; no `rf_we`. A repeat run with valid asserted on the 15th wait edge → write, no error.
- Illegal request: `NUM_SRC=3`, `wb_src=3` → `err_src` pulses one cycle; no write; state stays IDLE.
- Reset mid-WAIT, then parametric build: assert `rst_n=0` during WAIT → no write or error, `wb_busy=0` after the edge. Then `DATA_WIDTH=16`, `NUM_SRC=6`, `NUM_REGS=16`: source 5 = 0xBEEF to rd=15 → written correctly.
